button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 110 +++++++++++
 tb/tb_button_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions raw, bouncing push-button inputs for the stopwatch core. Each
// channel is synchronized by two flops, then debounced by a per-channel
// counter: the debounced level only follows the synchronized input once the
// two have disagreed for DEBOUNCE_CYCLES consecutive clocks. A registered
// one-cycle pulse marks every debounced rising and falling edge. Channel 3
// (pause button) drives a run/pause toggle.
//
// Channel map: 0 = reset button, 1 = select, 2 = adjust, 3 = pause.
//
// Parameters
//   DEBOUNCE_CYCLES  qualification length in clk cycles (legal 2..2^20)
//   NUM_BTN          number of button channels
//
// Ports
//   clk          in   1        system clock, rising-edge active
//   rst          in   1        synchronous active-high reset
//   btn_in       in   NUM_BTN  raw asynchronous button levels, 1 = pressed
//   btn_level    out  NUM_BTN  debounced level per channel
//   btn_rise     out  NUM_BTN  one-cycle pulse after btn_level goes 0->1
//   btn_fall     out  NUM_BTN  one-cycle pulse after btn_level goes 1->0
//   pause_state  out  1        run/pause flag, 1 = running
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int NUM_BTN         = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_rise,
   output logic [NUM_BTN-1:0] btn_fall,
   output logic               pause_state
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM     = CW'(DEBOUNCE_CYCLES - 1);
   localparam int            PAUSE_CH = 3;

   // Two-flop synchronizer; sync2 is the metastability-safe sample.
   logic [NUM_BTN-1:0] sync1;
   logic [NUM_BTN-1:0] sync2;

   // Per-channel qualification counters.
   logic [CW-1:0]      cnt [NUM_BTN];

   // Terminal count reached while input still disagrees with the level.
   logic [NUM_BTN-1:0] terminal;
   logic [NUM_BTN-1:0] level_next;
   logic [NUM_BTN-1:0] rise_next;
   logic [NUM_BTN-1:0] fall_next;
   logic               pause_toggle;

   always_comb begin
      terminal = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         terminal[i] = (sync2[i] != btn_level[i]) && (cnt[i] == TERM);
      end
      level_next = btn_level ^ terminal;
      // The new level equals sync2 on a terminal edge, so sync2 gives direction.
      rise_next  = terminal & sync2;
      fall_next  = terminal & ~sync2;
   end

   // The pause flag changes on the same edge that launches btn_rise[3], so the
   // new pause_state is visible during the btn_rise[3] cycle itself.
   generate
      if (NUM_BTN > PAUSE_CH) begin : g_pause
         assign pause_toggle = rise_next[PAUSE_CH];
      end else begin : g_no_pause
         assign pause_toggle = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1       <= '0;
         sync2       <= '0;
         btn_level   <= '0;
         btn_rise    <= '0;
         btn_fall    <= '0;
         pause_state <= 1'b1;
      end else begin
         sync1       <= btn_in;
         sync2       <= sync1;
         btn_level   <= level_next;
         btn_rise    <= rise_next;
         btn_fall    <= fall_next;
         pause_state <= pause_state ^ pause_toggle;
      end
   end

   // Counter clears whenever the input agrees with the level (a bounce back
   // restarts qualification) and on terminal count, so it never wraps.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BTN; i++) begin
         if (rst) begin
            cnt[i] <= '0;
         end else if ((sync2[i] == btn_level[i]) || terminal[i]) begin
            cnt[i] <= '0;
         end else begin
            cnt[i] <= cnt[i] + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4. Each step
// is planned up front as a stimulus word {rst, btn_in} plus the expected
// output word {pause_state, btn_fall, btn_rise, btn_level} sampled 1 ns after
// the following rising edge. A clean transition applied before edge 1 must
// show up after edge DEBOUNCE_CYCLES+2, with one pulse on that same sample.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int NB  = 4;
   localparam int DB  = 4;
   localparam int LAT = DB + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_in;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_rise;
   logic [NB-1:0] btn_fall;
   logic          pause_state;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .NUM_BTN        (NB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .btn_rise   (btn_rise),
      .btn_fall   (btn_fall),
      .pause_state(pause_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Scoreboard state
   logic [3*NB:0] exp_q [$];
   logic [NB:0]   stim_q[$];
   string         tag_q [$];
   int            checks = 0;
   int            errors = 0;
   logic [NB-1:0] exp_lvl;
   logic          exp_pause;
   string         cur;

   task automatic plan(input logic r, input logic [NB-1:0] b, input logic p,
                       input logic [NB-1:0] f, input logic [NB-1:0] rs,
                       input logic [NB-1:0] l);
      stim_q.push_back({r, b});
      exp_q.push_back({p, f, rs, l});
      tag_q.push_back(cur);
   endtask

   // Apply b from now on for n cycles; every channel settles to b after LAT
   // edges, pulsing on that edge. pause toggles if channel 3 rises.
   task automatic plan_hold(input logic [NB-1:0] b, input int n);
      logic [NB-1:0] old_l, new_l, r, f;
      logic          old_p, new_p;
      old_l = exp_lvl;
      new_l = b;
      r     = new_l & ~old_l;
      f     = old_l & ~new_l;
      old_p = exp_pause;
      new_p = old_p ^ r[3];
      for (int k = 1; k <= n; k++) begin
         if (k < LAT)       plan(1'b0, b, old_p, '0, '0, old_l);
         else if (k == LAT) plan(1'b0, b, new_p, f, r, new_l);
         else               plan(1'b0, b, new_p, '0, '0, new_l);
      end
      exp_lvl   = new_l;
      exp_pause = new_p;
   endtask

   // Driver + checker: pop one stimulus per cycle, compare after the edge.
   task automatic run_plan();
      logic [NB:0]   s;
      logic [3*NB:0] e;
      logic [3*NB:0] obs;
      string         t;
      while (stim_q.size() > 0) begin
         s      = stim_q.pop_front();
         rst    = s[NB];
         btn_in = s[NB-1:0];
         @(posedge clk);
         #1;
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         obs = {pause_state, btn_fall, btn_rise, btn_level};
         checks++;
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (pause,fall,rise,level)",
                   t, obs, e);
         end
      end
   endtask

   initial begin
      rst    = 1'b1;
      btn_in = '0;

      // Reset with random button noise; outputs clear, pause runs.
      cur = "reset";
      for (int i = 0; i < 3; i++) plan(1'b1, 4'($urandom_range(0, 15)), 1'b1, '0, '0, '0);
      plan(1'b1, '0, 1'b1, '0, '0, '0);
      exp_lvl   = '0;
      exp_pause = 1'b1;

      // No pulse right after release.
      cur = "post_reset_idle";
      for (int i = 0; i < 3; i++) plan(1'b0, '0, 1'b1, '0, '0, '0);

      // Clean press and release on select.
      cur = "clean_press_1";
      plan_hold(4'b0010, 8);
      cur = "release_1";
      plan_hold(4'b0000, 8);

      // Bounce on adjust: 3 high, 1 low, then held high.
      cur = "bounce_2";
      for (int i = 0; i < 3; i++) plan(1'b0, 4'b0100, exp_pause, '0, '0, exp_lvl);
      plan(1'b0, 4'b0000, exp_pause, '0, '0, exp_lvl);
      plan_hold(4'b0100, 8);
      cur = "release_2";
      plan_hold(4'b0000, 8);

      // Press then release on channel 0.
      cur = "press_0";
      plan_hold(4'b0001, 8);
      cur = "release_0";
      plan_hold(4'b0000, 8);

      // Two pause presses: 1 -> 0 -> 1.
      cur = "pause_press_a";
      plan_hold(4'b1000, 8);
      cur = "pause_release_a";
      plan_hold(4'b0000, 8);
      cur = "pause_press_b";
      plan_hold(4'b1000, 8);
      cur = "pause_release_b";
      plan_hold(4'b0000, 8);

      // Random bounces never long enough to qualify.
      cur = "rand_bounce";
      for (int i = 0; i < 6; i++) begin
         int h, l;
         h = $urandom_range(1, DB - 1);
         l = $urandom_range(1, 2);
         for (int k = 0; k < h; k++) plan(1'b0, 4'b0100, exp_pause, '0, '0, exp_lvl);
         for (int k = 0; k < l; k++) plan(1'b0, 4'b0000, exp_pause, '0, '0, exp_lvl);
      end
      for (int k = 0; k < 3; k++) plan(1'b0, 4'b0000, exp_pause, '0, '0, exp_lvl);

      // Reset in the middle of qualification on channel 3.
      cur = "rst_mid_count";
      for (int k = 0; k < 3; k++) plan(1'b0, 4'b1000, exp_pause, '0, '0, exp_lvl);
      for (int k = 0; k < 3; k++) plan(1'b1, 4'b1000, 1'b1, '0, '0, '0);
      exp_lvl   = '0;
      exp_pause = 1'b1;
      cur = "after_rst_press_3";
      plan_hold(4'b1000, 8);
      cur = "after_rst_release_3";
      plan_hold(4'b0000, 8);

      // All channels at once: one shared pulse cycle, one pause toggle.
      cur = "simultaneous_press";
      plan_hold(4'b1111, 8);
      cur = "simultaneous_release";
      plan_hold(4'b0000, 8);

      run_plan();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
